// File: rtl/kgprisc_pkg.sv
// rtl/kgprisc_pkg.sv - shared KGPRISC constants, opcode field bounds and fetch state encoding
package kgprisc_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam logic [5:0]  HALT_OP = 6'b111111;

    // Opcode field position inside a 32-bit instruction word
    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 26;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry instruction/PC holding register with push, pop and flush
module fetch_skid_buf #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [31:0]       push_data,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic              pop,
    output logic              valid,
    output logic [31:0]       data,
    output logic [ADDR_W-1:0] pc
);

    // Flush beats push beats pop; the sequencer never pushes while the entry is full
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
            data  <= push_data;
            pc    <= push_pc;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - KGPRISC instruction fetch sequencer (PC, imem requests, decode handshake); option FETCH_SKID_BUF_EN
module fetch_sequencer #(
    parameter int unsigned       ADDR_W   = kgprisc_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]        HALT_OP  = kgprisc_pkg::HALT_OP
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              halted
);

    import kgprisc_pkg::*;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc_q;
    logic              req_q;

    logic              transfer;
    logic              stalled;
    logic              room;
    logic              issue;
    logic              load_any;
    logic              drop_rsp;
    logic [31:0]       load_data;
    logic [ADDR_W-1:0] load_pc;

    assign imem_addr = pc;
    assign transfer  = inst_valid && inst_ready;
    assign stalled   = inst_valid && !inst_ready;

`ifdef FETCH_SKID_BUF_EN
    logic              skid_valid;
    logic [31:0]       skid_data;
    logic [ADDR_W-1:0] skid_pc;
    logic              skid_push;
    logic              skid_pop;
    logic              skid_flush;

    // A response meeting a stalled output parks in the skid entry; the entry refills the output on the next transfer
    always_comb begin
        skid_flush = redirect_valid && (state != IDLE);
        skid_push  = (state == RUN) && !redirect_valid && req_q && stalled;
        skid_pop   = (state == RUN) && !redirect_valid && skid_valid && transfer;
        drop_rsp   = 1'b0;
        // Only issue when the entry is empty now and will not be filled this cycle, so every response has a home
        room       = !skid_valid && !skid_push;
        load_any   = 1'b0;
        load_data  = imem_data;
        load_pc    = req_pc_q;
        if (skid_pop) begin
            load_any  = 1'b1;
            load_data = skid_data;
            load_pc   = skid_pc;
        end else if ((state == RUN) && req_q && !stalled) begin
            load_any  = 1'b1;
        end
    end

    fetch_skid_buf #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .flush     (skid_flush),
        .push      (skid_push),
        .push_data (imem_data),
        .push_pc   (req_pc_q),
        .pop       (skid_pop),
        .valid     (skid_valid),
        .data      (skid_data),
        .pc        (skid_pc)
    );
`else
    // A response meeting a stalled output is dropped and its address rewound for re-issue
    always_comb begin
        room      = !stalled;
        drop_rsp  = (state == RUN) && req_q && stalled;
        load_any  = (state == RUN) && req_q && !stalled;
        load_data = imem_data;
        load_pc   = req_pc_q;
    end
`endif

    assign issue = (state == RUN) && !redirect_valid && room;

    // FSM, PC sequencing, request tracking and the registered output stage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            req_q      <= 1'b0;
            req_pc_q   <= '0;
            inst_valid <= 1'b0;
            inst_out   <= '0;
            inst_pc    <= '0;
            halted     <= 1'b0;
        end else if (state == IDLE) begin
            state <= RUN;
        end else if (redirect_valid) begin
            // Redirect wins everywhere after IDLE: kill in-flight work and restart at the target
            state      <= RUN;
            halted     <= 1'b0;
            inst_valid <= 1'b0;
            req_q      <= 1'b0;
            pc         <= redirect_pc;
        end else begin
            req_q <= issue;
            if (issue) begin
                req_pc_q <= pc;
                pc       <= pc + PC_ONE;
            end
            if (drop_rsp) begin
                pc <= req_pc_q;
            end
            if (load_any) begin
                inst_valid <= 1'b1;
                inst_out   <= load_data;
                inst_pc    <= load_pc;
                // HALT stops fetch: discard whatever was issued behind it and park the PC just past it
                if (load_data[OPC_HI:OPC_LO] == HALT_OP) begin
                    state <= DRAIN;
                    req_q <= 1'b0;
                    pc    <= load_pc + PC_ONE;
                end
            end else if (transfer) begin
                inst_valid <= 1'b0;
            end
            if ((state == DRAIN) && transfer) begin
                state  <= HALTED;
                halted <= 1'b1;
            end
        end
    end

endmodule
